// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory controller: ready-handshake RAM access with store lane placement,
// load extraction/extension, pipeline stall and access timeout.
module mem_access_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_read_flag,
    input  logic                  mem_write_flag,
    input  logic                  mem_sign_ext_flag,
    input  logic [3:0]            mem_sel,
    input  logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic [DATA_WIDTH-1:0] result_in,
    input  logic                  reg_write_en_in,
    input  logic [4:0]            reg_write_addr_in,
    input  logic [DATA_WIDTH-1:0] current_pc_addr_in,
    input  logic [DATA_WIDTH-1:0] ram_read_data,
    input  logic                  ram_ready,
    output logic                  ram_en,
    output logic [3:0]            ram_write_en,
    output logic [DATA_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_write_data,
    output logic                  stall_request,
    output logic                  bus_error,
    output logic [DATA_WIDTH-1:0] result_out,
    output logic                  reg_write_en_out,
    output logic [4:0]            reg_write_addr_out,
    output logic [DATA_WIDTH-1:0] current_pc_addr_out
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    // Counter only has to reach TIMEOUT_CYCLES-1.
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t                  state_q;
    logic                    ram_en_q;
    logic [3:0]              ram_we_q;
    logic [DATA_WIDTH-1:0]   ram_addr_q;
    logic [DATA_WIDTH-1:0]   ram_wdata_q;
    logic                    bus_error_q;
    logic                    timeout_q;
    logic                    is_write_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [DATA_WIDTH-1:0]   rdata_q;

    logic                    mem_op;
    logic [1:0]              lane_d;
    logic [DATA_WIDTH-1:0]   wdata_d;
    logic [DATA_WIDTH-1:0]   rdata_d;

    function automatic logic [31:0] ext8(input logic [7:0] b, input logic s);
        return {{24{s & b[7]}}, b};
    endfunction

    function automatic logic [31:0] ext16(input logic [15:0] h, input logic s);
        return {{16{s & h[15]}}, h};
    endfunction

    assign mem_op = mem_read_flag | mem_write_flag;

    // Store data is right-aligned; shift it up to the lowest enabled lane.
    always_comb begin
        lane_d = 2'd0;
        if (mem_sel[0])      lane_d = 2'd0;
        else if (mem_sel[1]) lane_d = 2'd1;
        else if (mem_sel[2]) lane_d = 2'd2;
        else if (mem_sel[3]) lane_d = 2'd3;
        wdata_d = mem_write_data << {lane_d, 3'b000};
    end

    always_comb begin
        rdata_d = ram_read_data;
        case (mem_sel)
            4'b0001: rdata_d = ext8(ram_read_data[7:0],   mem_sign_ext_flag);
            4'b0010: rdata_d = ext8(ram_read_data[15:8],  mem_sign_ext_flag);
            4'b0100: rdata_d = ext8(ram_read_data[23:16], mem_sign_ext_flag);
            4'b1000: rdata_d = ext8(ram_read_data[31:24], mem_sign_ext_flag);
            4'b0011: rdata_d = ext16(ram_read_data[15:0],  mem_sign_ext_flag);
            4'b1100: rdata_d = ext16(ram_read_data[31:16], mem_sign_ext_flag);
            default: rdata_d = ram_read_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 4'b0000;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            bus_error_q <= 1'b0;
            timeout_q   <= 1'b0;
            is_write_q  <= 1'b0;
            cnt_q       <= '0;
            rdata_q     <= '0;
        end else begin
            bus_error_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mem_op) begin
                        ram_en_q    <= 1'b1;
                        ram_addr_q  <= {result_in[DATA_WIDTH-1:2], 2'b00};
                        ram_we_q    <= mem_write_flag ? mem_sel : 4'b0000;
                        ram_wdata_q <= wdata_d;
                        is_write_q  <= mem_write_flag;
                        timeout_q   <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (ram_ready) begin
                        rdata_q  <= rdata_d;
                        ram_en_q <= 1'b0;
                        ram_we_q <= 4'b0000;
                        state_q  <= DONE;
                    end else if (TIMEOUT_CYCLES != 0 && cnt_q == CNT_LAST) begin
                        rdata_q     <= '0;
                        ram_en_q    <= 1'b0;
                        ram_we_q    <= 4'b0000;
                        bus_error_q <= 1'b1;
                        timeout_q   <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ram_en         = ram_en_q;
    assign ram_write_en   = ram_we_q;
    assign ram_addr       = ram_addr_q;
    assign ram_write_data = ram_wdata_q;
    assign bus_error      = bus_error_q;

    assign stall_request = (state_q == ACCESS) || (state_q == IDLE && mem_op);

    // In DONE a load hands back the formatted word; everything else passes result_in.
    assign result_out          = (state_q == DONE && !is_write_q) ? rdata_q : result_in;
    assign reg_write_en_out    = reg_write_en_in & ~(state_q == DONE && timeout_q);
    assign reg_write_addr_out  = reg_write_addr_in;
    assign current_pc_addr_out = current_pc_addr_in;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed vector table, reset-in-ACCESS sequence,
// and randomized transactions checked against a transaction-level reference model.
module tb_mem_access_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read_flag, mem_write_flag, mem_sign_ext_flag;
    logic [3:0]  mem_sel;
    logic [31:0] mem_write_data, result_in, current_pc_addr_in, ram_read_data;
    logic        reg_write_en_in, ram_ready;
    logic [4:0]  reg_write_addr_in;
    logic        ram_en, stall_request, bus_error, reg_write_en_out;
    logic [3:0]  ram_write_en;
    logic [31:0] ram_addr, ram_write_data, result_out, current_pc_addr_out;
    logic [4:0]  reg_write_addr_out;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .mem_read_flag(mem_read_flag), .mem_write_flag(mem_write_flag),
        .mem_sign_ext_flag(mem_sign_ext_flag), .mem_sel(mem_sel),
        .mem_write_data(mem_write_data), .result_in(result_in),
        .reg_write_en_in(reg_write_en_in), .reg_write_addr_in(reg_write_addr_in),
        .current_pc_addr_in(current_pc_addr_in), .ram_read_data(ram_read_data),
        .ram_ready(ram_ready), .ram_en(ram_en), .ram_write_en(ram_write_en),
        .ram_addr(ram_addr), .ram_write_data(ram_write_data),
        .stall_request(stall_request), .bus_error(bus_error),
        .result_out(result_out), .reg_write_en_out(reg_write_en_out),
        .reg_write_addr_out(reg_write_addr_out), .current_pc_addr_out(current_pc_addr_out)
    );

    typedef struct {
        logic        rd, wr, sext;
        logic [3:0]  sel;
        logic [31:0] wdata, addr, rdata;
        int          ready_at;    // ACCESS cycle (1-based) where ram_ready rises; 0 = never
        logic        we_in;
        logic [31:0] exp_addr;
        logic [3:0]  exp_we;
        logic [31:0] exp_wdata, exp_result;
        int          exp_access;  // number of ACCESS cycles
        logic        exp_err;
        logic        exp_rwe;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Transaction-level reference: byte arithmetic on the whole request, no state machine.
    function automatic vec_t model(input vec_t v);
        vec_t        r;
        int          idx;
        bit          found;
        logic [31:0] loaded;
        bit          ok;
        r = v;
        idx = 0;
        found = 0;
        for (int i = 0; i < 4; i++)
            if (!found && v.sel[i]) begin idx = i; found = 1; end
        r.exp_addr  = v.addr - (v.addr % 4);
        r.exp_wdata = v.wdata << (8 * idx);
        r.exp_we    = v.wr ? v.sel : 4'b0000;
        case (v.sel)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: begin
                loaded = (v.rdata >> (8 * idx)) & 32'h0000_00FF;
                if (v.sext && loaded >= 32'd128) loaded = loaded + 32'hFFFF_FF00;
            end
            4'b0011, 4'b1100: begin
                loaded = (v.rdata >> (8 * idx)) & 32'h0000_FFFF;
                if (v.sext && loaded >= 32'd32768) loaded = loaded + 32'hFFFF_0000;
            end
            default: loaded = v.rdata;
        endcase
        if (!v.rd && !v.wr) begin
            r.exp_access = 0;
            r.exp_err    = 1'b0;
            r.exp_result = v.addr;
            r.exp_rwe    = v.we_in;
        end else begin
            ok = (v.ready_at >= 1) && (v.ready_at <= TO);
            r.exp_access = ok ? v.ready_at : TO;
            r.exp_err    = !ok;
            r.exp_result = v.wr ? v.addr : (ok ? loaded : 32'h0);
            r.exp_rwe    = ok ? v.we_in : 1'b0;
        end
        return r;
    endfunction

    // Called just after a rising edge with the DUT in IDLE; returns just after the edge leaving DONE.
    task automatic apply(input int id, input vec_t v);
        logic [4:0]  rd_addr;
        logic [31:0] pc;
        bit          done;
        rd_addr = 5'($urandom_range(0, 31));
        pc      = $urandom;
        mem_read_flag = v.rd; mem_write_flag = v.wr; mem_sign_ext_flag = v.sext;
        mem_sel = v.sel; mem_write_data = v.wdata; result_in = v.addr;
        ram_read_data = v.rdata; reg_write_en_in = v.we_in;
        reg_write_addr_in = rd_addr; current_pc_addr_in = pc;
        @(negedge clk);
        chk("idle_bus_error", 32'(bus_error), 32'h0);
        chk("idle_ram_en", 32'(ram_en), 32'h0);
        chk("pass_rd_addr", 32'(reg_write_addr_out), 32'(rd_addr));
        chk("pass_pc", current_pc_addr_out, pc);
        if (!v.rd && !v.wr) begin
            chk("alu_stall", 32'(stall_request), 32'h0);
            chk("alu_result", result_out, v.exp_result);
            chk("alu_rwe", 32'(reg_write_en_out), 32'(v.exp_rwe));
            $display("[TB] txn %0d alu result=0x%08h", id, result_out);
            @(posedge clk); #1;
            return;
        end
        chk("idle_stall", 32'(stall_request), 32'h1);
        ram_ready = 1'($urandom_range(0, 1));
        done = 0;
        for (int k = 1; k < 16 && !done; k++) begin
            @(negedge clk);
            if (stall_request) begin
                chk("acc_ram_en", 32'(ram_en), 32'h1);
                chk("acc_ram_addr", ram_addr, v.exp_addr);
                chk("acc_ram_we", 32'(ram_write_en), 32'(v.exp_we));
                chk("acc_ram_wdata", ram_write_data, v.exp_wdata);
                chk("acc_bus_error", 32'(bus_error), 32'h0);
                ram_ready = (v.ready_at == k);
            end else begin
                done = 1;
                ram_ready = 1'b0;
                chk("access_cycles", 32'(k - 1), 32'(v.exp_access));
                chk("done_result", result_out, v.exp_result);
                chk("done_rwe", 32'(reg_write_en_out), 32'(v.exp_rwe));
                chk("done_bus_error", 32'(bus_error), 32'(v.exp_err));
                chk("done_ram_en", 32'(ram_en), 32'h0);
                chk("done_ram_we", 32'(ram_write_en), 32'h0);
                $display("[TB] txn %0d %s addr=0x%08h access=%0d result=0x%08h err=%0d",
                         id, v.wr ? "store" : "load", v.addr, k - 1, result_out, bus_error);
            end
        end
        if (!done) chk("stall_release", 32'(stall_request), 32'h0);
        @(posedge clk); #1;
    endtask

    task automatic idle_inputs();
        mem_read_flag = 0; mem_write_flag = 0; mem_sign_ext_flag = 0; mem_sel = 4'h0;
        mem_write_data = 0; result_in = 0; reg_write_en_in = 0; reg_write_addr_in = 0;
        current_pc_addr_in = 0; ram_read_data = 0; ram_ready = 0;
    endtask

    vec_t tbl[12];
    vec_t rv;

    initial begin
        // rd wr sext sel wdata addr rdata ready_at we_in | exp_addr exp_we exp_wdata exp_result access err rwe
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 4'b0100, 32'h0, 32'h100, 32'h0080_0000, 1, 1'b1,
                    32'h100, 4'b0000, 32'h0, 32'hFFFF_FF80, 1, 1'b0, 1'b1};
        tbl[1]  = '{1'b0, 1'b1, 1'b0, 4'b1100, 32'h0000_BEEF, 32'h202, 32'h0, 1, 1'b0,
                    32'h200, 4'b1100, 32'hBEEF_0000, 32'h202, 1, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 4'b1111, 32'h0, 32'h40, 32'h1234_5678, 4, 1'b1,
                    32'h40, 4'b0000, 32'h0, 32'h1234_5678, 4, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 4'b1111, 32'h0, 32'h44, 32'hAAAA_AAAA, 0, 1'b1,
                    32'h44, 4'b0000, 32'h0, 32'h0, 4, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 4'b0000, 32'h0, 32'hDEAD_BEEF, 32'h0, 0, 1'b1,
                    32'h0, 4'b0000, 32'h0, 32'hDEAD_BEEF, 0, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 4'b0010, 32'h0, 32'h31, 32'h0000_9A00, 2, 1'b1,
                    32'h30, 4'b0000, 32'h0, 32'h0000_009A, 2, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 1'b0, 1'b1, 4'b0011, 32'h0, 32'h8, 32'h1234_8001, 1, 1'b1,
                    32'h8, 4'b0000, 32'h0, 32'hFFFF_8001, 1, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 4'b0001, 32'h55, 32'h13, 32'h0, 3, 1'b1,
                    32'h10, 4'b0001, 32'h55, 32'h13, 3, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 4'b0000, 32'hCAFE_F00D, 32'h7, 32'h0, 2, 1'b0,
                    32'h4, 4'b0000, 32'hCAFE_F00D, 32'h7, 2, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 4'b0101, 32'h0, 32'h20, 32'h8765_4321, 1, 1'b1,
                    32'h20, 4'b0000, 32'h0, 32'h8765_4321, 1, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 4'b1100, 32'h0, 32'h2C, 32'hF00D_1234, 1, 1'b1,
                    32'h2C, 4'b0000, 32'h0, 32'h0000_F00D, 1, 1'b0, 1'b1};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 4'b1000, 32'hA5, 32'h50, 32'h0, 0, 1'b1,
                    32'h50, 4'b1000, 32'hA500_0000, 32'h50, 4, 1'b1, 1'b0};

        idle_inputs();
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_ram_en", 32'(ram_en), 32'h0);
        chk("rst_ram_we", 32'(ram_write_en), 32'h0);
        chk("rst_ram_addr", ram_addr, 32'h0);
        chk("rst_ram_wdata", ram_write_data, 32'h0);
        chk("rst_bus_error", 32'(bus_error), 32'h0);
        chk("rst_stall", 32'(stall_request), 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;

        for (int i = 0; i < 12; i++) apply(i, tbl[i]);

        // Reset while an access is waiting on the RAM.
        mem_read_flag = 1; mem_sel = 4'b1111; result_in = 32'h88; ram_ready = 0;
        reg_write_en_in = 1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstacc_pre_ram_en", 32'(ram_en), 32'h1);
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        idle_inputs();
        result_in = 32'h1111_2222;
        reg_write_en_in = 1;
        @(negedge clk);
        chk("rstacc_ram_en", 32'(ram_en), 32'h0);
        chk("rstacc_ram_addr", ram_addr, 32'h0);
        chk("rstacc_bus_error", 32'(bus_error), 32'h0);
        chk("rstacc_stall", 32'(stall_request), 32'h0);
        chk("rstacc_result", result_out, 32'h1111_2222);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rstacc_no_done_err", 32'(bus_error), 32'h0);
            chk("rstacc_no_done_rwe", 32'(reg_write_en_out), 32'h1);
        end
        @(posedge clk); #1;
        $display("[TB] reset-in-access sequence complete");

        for (int n = 0; n < 40; n++) begin
            int kind;
            kind = $urandom_range(0, 9);
            rv = tbl[0];
            rv.rd    = (kind >= 2 && kind <= 5) || kind == 9;
            rv.wr    = kind >= 6;
            rv.sext  = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 8))
                0: rv.sel = 4'b0001;
                1: rv.sel = 4'b0010;
                2: rv.sel = 4'b0100;
                3: rv.sel = 4'b1000;
                4: rv.sel = 4'b0011;
                5: rv.sel = 4'b1100;
                6: rv.sel = 4'b1111;
                default: rv.sel = 4'($urandom_range(0, 15));
            endcase
            rv.wdata    = $urandom;
            rv.addr     = $urandom;
            rv.rdata    = $urandom;
            rv.ready_at = $urandom_range(0, 6);
            rv.we_in    = 1'($urandom_range(0, 1));
            rv = model(rv);
            apply(100 + n, rv);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
MEM-stage data-memory controller that consumes the load/store request produced by the execute stage and carries it out on the data-RAM bus. It performs a ready-based handshake, places byte lanes for stores, and extracts and sign- or zero-extends load data. While a transaction is outstanding it holds the pipeline through a stall request. Non-memory instructions pass straight through to WB with no added latency.

Parameters:
DATA_WIDTH, 32, data and address width; only 32 is supported.
TIMEOUT_CYCLES, 255, maximum ACCESS cycles to wait for ram_ready; 0 disables the timeout.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous, active-low reset.
mem_read_flag  in  1  load request from EX.
mem_write_flag  in  1  store request from EX.
mem_sign_ext_flag  in  1  sign-extend load data when 1, zero-extend when 0.
mem_sel  in  4  byte-lane enables.
mem_write_data  in  32  store data, right-aligned.
result_in  in  32  ALU result from EX; for loads and stores this is the effective address.
reg_write_en_in  in  1  register write enable from EX.
reg_write_addr_in  in  5  destination register.
current_pc_addr_in  in  32  PC of the instruction.
ram_read_data  in  32  word read from RAM.
ram_ready  in  1  RAM completes the current access in this cycle.
ram_en  out  1  access request to RAM.
ram_write_en  out  4  per-byte write strobes.
ram_addr  out  32  word-aligned address.
ram_write_data  out  32  lane-placed store data.
stall_request  out  1  asks upstream stages to hold.
bus_error  out  1  one-cycle pulse when an access times out.
result_out  out  32  value passed to WB.
reg_write_en_out  out  1  register write enable to WB.
reg_write_addr_out  out  5  destination register to WB.
current_pc_addr_out  out  32  PC passed to WB.

Behaviour:
- All EX-side inputs come from the EX/MEM register, which holds them steady while stall_request=1.
- mem_op = mem_read_flag | mem_write_flag. If both flags are 1, the request is treated as a write.
- States: IDLE, ACCESS, DONE.
- Reset (rst=0 at a clk edge):
  - state goes to IDLE.
  - ram_en, ram_write_en, ram_addr, ram_write_data, bus_error, the timeout counter and the load-data register rdata_q all clear to 0.
  - An ACCESS in progress is abandoned; ram_en is low after that edge.
- IDLE:
  - If mem_op=0: stall_request=0 and the block is a pure pass-through. result_out=result_in; the other WB outputs copy their inputs.
  - If mem_op=1: stall_request=1 combinationally. At the next edge, register the bus outputs and go to ACCESS:
    - ram_en=1.
    - ram_addr={result_in[31:2],2'b00}.
    - ram_write_en = mem_sel for a write, 4'b0000 for a read.
    - ram_write_data = mem_write_data << (8 × index of the lowest set bit of mem_sel); mem_sel=0 gives index 0.
    - The counter clears.
- ACCESS:
  - stall_request=1 and all bus outputs are held stable.
  - If ram_ready=1, format ram_read_data into rdata_q, drop ram_en and ram_write_en, and go to DONE. A zero-wait RAM therefore completes in the first ACCESS cycle.
  - If ram_ready=0, the counter increments. When TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES-1 without ready:
    - drop ram_en, set rdata_q=0;
    - pulse bus_error=1 during the DONE cycle;
    - go to DONE with the error flagged.
- Load formatting by mem_sel:
  - 0001, 0010, 0100, 1000: select byte 0, 1, 2 or 3, extended to 32 bits.
  - 0011 or 1100: select the low or high halfword, extended.
  - 1111 or any other pattern: the raw word.
- DONE:
  - stall_request=0.
  - result_out = rdata_q for a read, result_in for a write.
  - reg_write_en_out = reg_write_en_in, except forced to 0 when the access timed out.
  - Next edge goes to IDLE. The pipeline advances at that same edge, so the same request never re-triggers.
- Latency: a memory operation spends 1 cycle in IDLE, N≥1 in ACCESS and 1 in DONE, so it costs N+1 stall cycles. A non-memory instruction costs 0.
- The pass-through outputs reg_write_addr_out and current_pc_addr_out always copy their inputs.
- At most one transaction is outstanding at a time. Address bits [1:0] never reach the bus.

Test Plan:
- Zero-wait load: read=1, sign_ext=1, sel=0100, result_in=0x100, ram_ready held 1, ram_read_data=0x0080_0000. Required: ram_addr=0x100, ram_write_en=0, stall high for 2 cycles, result_out=0xFFFF_FF80 in DONE.
- Store halfword: write=1, sel=1100, mem_write_data=0x0000_BEEF, result_in=0x202. Required: ram_addr=0x200, ram_write_en=1100, ram_write_data=0xBEEF_0000, reg_write_en_out=0.
- Wait states: ram_ready asserted only on the 4th ACCESS cycle for a word load of 0x1234_5678. Required: bus outputs stable throughout, stall high for 5 cycles, result_out=0x1234_5678.
- Timeout: TIMEOUT_CYCLES=4, ram_ready held 0. Required: ram_en drops after 4 ACCESS cycles, bus_error pulses 1 cycle, result_out=0, reg_write_en_out=0.
- Non-memory ALU op with result_in=0xDEAD_BEEF. Required: stall_request=0, result_out=0xDEAD_BEEF in the same cycle, ram_en stays 0.
- Reset while in ACCESS (rst=0 for 1 cycle). Required: ram_en=0 and state IDLE after the edge, bus_error=0, no DONE cycle.
